// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Operation and state encodings shared by the sequential divider.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // op[0] clear selects the signed flavour, op[1] set selects the remainder
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One radix-2 restoring division iteration (combinational).
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] div_in,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    // Partial remainder stays below the divisor, so a borrow out of bit WIDTH
    // is exactly the "shifted remainder < divisor" condition.
    always_comb begin
        w_shift = {rem_in, quo_in[WIDTH-1]};
        w_trial = w_shift - {1'b0, div_in};
        if (!w_trial[WIDTH]) begin
            rem_out = w_trial[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_out = w_shift[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle signed/unsigned divider (quotient or remainder).
//               Define SEQ_DIVIDER_EARLY_OUT_EN to finish divide-by-zero and
//               signed overflow one cycle after acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_result;

    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_final;
    logic             w_accept;
    logic             w_last;
    logic             w_finish;
    logic             w_sgn;
    logic             w_rem_op;
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_div0;
    logic             w_ovf;

    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (r_rem),
        .quo_in  (r_quo),
        .div_in  (r_div),
        .rem_out (w_rem_nxt),
        .quo_out (w_quo_nxt)
    );

    assign busy      = (r_state == ST_CALC);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;

    assign w_accept = start && !busy && !flush;
    assign w_sgn    = op_is_signed(r_op);
    assign w_rem_op = op_is_rem(r_op);
    assign w_a_neg  = w_sgn && r_a[WIDTH-1];
    assign w_b_neg  = w_sgn && r_b[WIDTH-1];
    assign w_div0   = (r_b == '0);
    assign w_ovf    = w_sgn && (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&r_b);
    // Counter reaching WIDTH means all iterations are done; that cycle applies signs.
    assign w_last   = (r_cnt == CNT_W'(WIDTH));
    assign w_finish = w_last || (EARLY_OUT && (w_div0 || w_ovf));

    always_comb begin
        if (w_div0)
            w_final = w_rem_op ? r_a : '1;
        else if (w_ovf)
            w_final = w_rem_op ? '0 : r_a;
        else if (w_rem_op)
            w_final = w_a_neg ? -r_rem : r_rem;
        else
            w_final = (w_a_neg ^ w_b_neg) ? -r_quo : r_quo;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (start) w_state_nxt = ST_CALC;
                ST_CALC: if (w_finish) w_state_nxt = ST_DONE;
                ST_DONE: w_state_nxt = start ? ST_CALC : ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_op  <= op;
            r_a   <= dividend;
            r_b   <= divisor;
            r_rem <= '0;
            r_quo <= f_mag(dividend, op_is_signed(op));
            r_div <= f_mag(divisor, op_is_signed(op));
        end else if (busy && !flush) begin
            if (w_finish) begin
                r_result <= w_final;
            end else begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Scoreboard bench for seq_divider at WIDTH=32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;
    import div_pkg::*;

    logic        CLK;
    logic        RESET;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        out_valid;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    seq_divider #(.WIDTH(32)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (start),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .flush     (flush),
        .busy      (busy),
        .out_valid (out_valid),
        .result    (result)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb_;
        sa  = a;
        sb_ = b;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : a;
        case (o)
            OP_DIV:  return 32'(sa / sb_);
            OP_REM:  return 32'(sa % sb_);
            OP_DIVU: return a / b;
            default: return a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
        if (b == 32'd0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
        return 33;
    endfunction

    // Caller sits at a negedge; acceptance happens at the following posedge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
        exp_t e;
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        e.res = exp;
        e.acc = cyc + 1;
        e.lat = exp_lat(o, a, b);
        e.tag = tag;
        sb.push_back(e);
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge CLK);
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 100 && out_valid !== 1'b1; i++) @(negedge CLK);
        check(tag, 64'(out_valid), 64'd1);
    endtask

    always @(posedge CLK) begin
        #1;
        if (out_valid === 1'b1) begin
            check("busy_in_valid", 64'(busy), 64'd0);
            if (sb.size() == 0) begin
                check("no_valid", 64'(out_valid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check({"res_", mon_e.tag}, 64'(result), 64'(mon_e.res));
                check({"lat_", mon_e.tag}, 64'(cyc - mon_e.acc), 64'(mon_e.lat));
            end
        end
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        RESET = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;

        @(negedge CLK); issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2"); wait_idle();
        repeat (3) @(negedge CLK);
        check("hold", 64'(result), 64'hFFFF_FFFD);
        @(negedge CLK); issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2"); wait_idle();
        @(negedge CLK); issue(OP_DIVU, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, "divu_z"); wait_idle();
        @(negedge CLK); issue(OP_REMU, 32'd5, 32'd0, 32'd5, "remu_z"); wait_idle();
        @(negedge CLK); issue(OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, "div_z"); wait_idle();
        @(negedge CLK); issue(OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, "rem_z"); wait_idle();
        @(negedge CLK); issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"); wait_idle();
        @(negedge CLK); issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf"); wait_idle();

        // back-to-back: second start lands in the first result's valid cycle
        @(negedge CLK); issue(OP_DIVU, 32'd100, 32'd7, 32'd14, "b2b_divu");
        wait_valid("b2b_valid_seen");
        issue(OP_REMU, 32'd100, 32'd7, 32'd2, "b2b_remu");
        wait_idle();

        // start while busy must be ignored
        @(negedge CLK); issue(OP_DIVU, 32'd1000, 32'd7, 32'd142, "ign_divu");
        repeat (5) @(negedge CLK);
        check("ign_busy", 64'(busy), 64'd1);
        start = 1'b1; op = OP_REMU; dividend = 32'd55; divisor = 32'd3;
        @(negedge CLK); start = 1'b0;
        wait_idle();

        // flush mid-operation: nothing may come out
        @(negedge CLK); start = 1'b1; op = OP_DIVU; dividend = 32'd1000; divisor = 32'd3;
        @(negedge CLK); start = 1'b0;
        repeat (9) @(negedge CLK);
        flush = 1'b1;
        @(negedge CLK); flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge CLK);
        issue(OP_DIVU, 32'd9, 32'd3, 32'd3, "after_flush"); wait_idle();

        // flush beats a simultaneous start
        @(negedge CLK); start = 1'b1; flush = 1'b1; op = OP_DIVU; dividend = 32'd8; divisor = 32'd2;
        @(negedge CLK); start = 1'b0; flush = 1'b0;
        check("flush_start_drop", 64'(busy), 64'd0);
        repeat (40) @(negedge CLK);

        // flush during the valid cycle leaves the pulse intact
        issue(OP_DIVU, 32'd50, 32'd5, 32'd10, "flush_on_valid");
        wait_valid("fv_valid_seen");
        flush = 1'b1; #1;
        check("flush_keep_valid", 64'(out_valid), 64'd1);
        @(negedge CLK); flush = 1'b0;
        wait_idle();

        for (int i = 0; i < 12; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : ((i % 3 == 1) ? 32'(-$urandom_range(1, 20)) : $urandom);
            @(negedge CLK); issue(ro, ra, rb, model(ro, ra, rb), $sformatf("rnd%0d", i)); wait_idle();
        end

        // asynchronous reset mid-operation
        @(negedge CLK); start = 1'b1; op = OP_DIVU; dividend = 32'd1000; divisor = 32'd3;
        @(negedge CLK); start = 1'b0;
        repeat (4) @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_result", 64'(result), 64'd0);
        @(negedge CLK); RESET = 1'b0;
        repeat (40) @(negedge CLK);
        issue(OP_DIVU, 32'd20, 32'd4, 32'd5, "after_rst"); wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; legal values are even and 8 to 64.
REQ-002 Port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit: request a division; sampled only when busy is low.
REQ-005 Port op, input, 2 bits: operation select.
- 00 DIV (signed quotient)
- 01 DIVU (unsigned quotient)
- 10 REM (signed remainder)
- 11 REMU (unsigned remainder)
REQ-006 Port dividend, input, WIDTH bits: operand A, captured when start is accepted.
REQ-007 Port divisor, input, WIDTH bits: operand B, captured when start is accepted.
REQ-008 Port flush, input, 1 bit: abort any operation in flight.
REQ-009 Port busy, output, 1 bit: an operation is in progress.
REQ-010 Port out_valid, output, 1 bit: single-cycle pulse marking result as valid.
REQ-011 Port result, output, WIDTH bits: quotient or remainder, as selected by the captured op.

Function
REQ-012 Start SHALL be accepted on a rising edge where start=1, busy=0 and flush=0; op and operands are registered at that edge (edge k).
REQ-013 States SHALL be IDLE, CALC and DONE.
- IDLE -> CALC on acceptance.
- CALC -> DONE after WIDTH iterations.
- DONE -> IDLE, or DONE -> CALC if a new start is accepted in that cycle.
REQ-014 CALC SHALL run one radix-2 restoring iteration per cycle on operand magnitudes, with an iteration counter of clog2(WIDTH)+1 bits.
REQ-015 For normal operands, out_valid SHALL be high for exactly the cycle following edge k+WIDTH+1, giving 33 cycles of latency at WIDTH=32.
REQ-016 Busy SHALL be high from edge k until out_valid rises, and low during the out_valid cycle, so a start can be accepted back-to-back.
REQ-017 Start while busy=1 SHALL be ignored without side effects.
REQ-018 Signed ops SHALL negate the quotient when the operand signs differ, and give the remainder the sign of the dividend.
REQ-019 Divisor=0 SHALL give quotient all-ones for DIV and DIVU, and remainder = dividend for REM and REMU.
REQ-020 Signed overflow (dividend = most-negative value, divisor = -1) SHALL give DIV result = dividend and REM result = 0.
REQ-021 Result SHALL hold its last value until the next out_valid; it changes only at the edge that raises out_valid.
REQ-022 Flush=1 SHALL return the block to IDLE at the next edge, with no out_valid produced; flush wins over a simultaneous start, and that start is dropped.
REQ-023 Flush in the same cycle as out_valid SHALL NOT retract that pulse.

Reset
REQ-024 RESET SHALL immediately force:
- state IDLE, counter 0;
- busy=0, out_valid=0, result=0;
- internal operand and partial-remainder registers to 0.
REQ-025 RESET asserted mid-operation SHALL discard the operation; no out_valid follows the release of RESET.

Configuration
REQ-026 Macro SEQ_DIVIDER_EARLY_OUT_EN SHALL control early completion of special cases.
- Defined: divide-by-zero and signed overflow skip CALC; out_valid is high in the cycle after edge k+1 with the REQ-019/REQ-020 values.
- Not defined: those cases take the normal REQ-015 latency, with identical result values.

Structure
REQ-027 Package div_pkg SHALL hold the op encoding constants (OP_DIV, OP_DIVU, OP_REM, OP_REMU) and the state encoding (ST_IDLE, ST_CALC, ST_DONE).
REQ-028 One combinational sub-module, div_step, SHALL implement a single restoring iteration: (partial remainder, quotient, divisor) -> next values.

Verification
REQ-029 DIV with dividend=-7 and divisor=2 (WIDTH=32) -> result=-3 (0xFFFFFFFD) after 33 cycles; REM with the same operands -> result=-1.
REQ-030 DIVU with dividend=0xFFFFFFFF and divisor=0 -> result=0xFFFFFFFF; REMU with dividend=5 and divisor=0 -> result=5.
- Check latency at 33 cycles without the macro and 1 cycle with it.
REQ-031 DIV with dividend=0x80000000 and divisor=0xFFFFFFFF -> result=0x80000000; REM with the same operands -> result=0.
REQ-032 Back-to-back: start DIVU 100/7 and then, during its out_valid cycle, start REMU 100/7 -> results 14 then 2, each with a single out_valid pulse.
REQ-033 Flush at cycle 10 of DIVU 1000/3 -> no out_valid, busy=0 next cycle; a following start with DIVU 9/3 -> result 3.
REQ-034 RESET pulse at cycle 5 of an operation -> all outputs 0 immediately; no out_valid afterwards.
